// File: rtl/afe_roic_pkg.sv
// rtl/afe_roic_pkg.sv - shared types, register map and helper functions for the ROIC stream model
package afe_roic_pkg;

   typedef enum logic [1:0] {
      MODE_NORMAL = 2'd0,
      MODE_RAMP   = 2'd1,
      MODE_FIXED  = 2'd2,
      MODE_SLEEP  = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_LINE,
      ST_GAP,
      ST_DONE
   } state_e;

   localparam logic [6:0] ADDR_CTRL   = 7'h00;
   localparam logic [6:0] ADDR_MODE   = 7'h01;
   localparam logic [6:0] ADDR_FIXED  = 7'h02;
   localparam logic [6:0] ADDR_LINES  = 7'h03;
   localparam logic [6:0] ADDR_STATUS = 7'h04;
   localparam logic [6:0] ADDR_INJ    = 7'h05;

   // Alternating 1010... pattern of the given width with its MSB set.
   function automatic logic [15:0] train_word(input int width);
      logic [15:0] w;
      w = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < width && ((width - 1 - i) % 2) == 0) w[i] = 1'b1;
      end
      return w;
   endfunction

   // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/afe_roic_stream_model_if.sv
// rtl/afe_roic_stream_model_if.sv - SPI and LVDS lane bundle between the ROIC model and its host
interface afe_roic_stream_model_if #(
   parameter int NUM_CH = 14
);
   logic              spi_sck;
   logic              spi_sdi;
   logic              spi_sen_n;
   logic              spi_sdo;
   logic [NUM_CH-1:0] dclk_p;
   logic [NUM_CH-1:0] dclk_n;
   logic [NUM_CH-1:0] fclk_p;
   logic [NUM_CH-1:0] fclk_n;
   logic [NUM_CH-1:0] dout_p;
   logic [NUM_CH-1:0] dout_n;

   modport master (
      output spi_sck, spi_sdi, spi_sen_n,
      input  spi_sdo, dclk_p, dclk_n, fclk_p, fclk_n, dout_p, dout_n
   );

   modport slave (
      input  spi_sck, spi_sdi, spi_sen_n,
      output spi_sdo, dclk_p, dclk_n, fclk_p, fclk_n, dout_p, dout_n
   );
endinterface

// File: rtl/afe_roic_spi_slave.sv
// rtl/afe_roic_spi_slave.sv - SPI register slave; ROIC_ERR_INJECT_EN adds the INJ register
module afe_roic_spi_slave
   import afe_roic_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_sck,
   input  logic        spi_sdi,
   input  logic        spi_sen_n,
   output logic        spi_sdo,
   input  logic [15:0] status,
`ifdef ROIC_ERR_INJECT_EN
   input  logic        inj_clr,
   output logic [15:0] inj,
`endif
   output mode_e       mode,
   output logic [15:0] fixed,
   output logic [15:0] lines,
   output logic        soft_rst,
   output logic        status_rd
);
   logic [2:0]  sck_q;
   logic [1:0]  sdi_q;
   logic [1:0]  sen_q;
   logic [4:0]  cnt;
   logic [22:0] sh;
   logic [15:0] rd_sh;
   logic [15:0] rd_val;
   logic        is_rd;
   logic        rise;
   logic        fall;
   logic        sdi_s;
   logic        sen_s;
   logic        wr_en;
   logic [6:0]  rd_addr;
   logic [6:0]  wr_addr;
   logic [15:0] wr_data;

   assign rise    = sck_q[1] & ~sck_q[2];
   assign fall    = ~sck_q[1] & sck_q[2];
   assign sdi_s   = sdi_q[1];
   assign sen_s   = sen_q[1];
   assign rd_addr = {sh[5:0], sdi_s};
   assign wr_addr = sh[21:15];
   assign wr_data = {sh[14:0], sdi_s};
   assign wr_en   = rise & ~sen_s & (cnt == 5'd23) & ~sh[22];

   always_comb begin
      rd_val = '0;
      case (rd_addr)
         ADDR_MODE:   rd_val = {14'd0, mode};
         ADDR_FIXED:  rd_val = fixed;
         ADDR_LINES:  rd_val = lines;
         ADDR_STATUS: rd_val = status;
`ifdef ROIC_ERR_INJECT_EN
         ADDR_INJ:    rd_val = inj;
`endif
         default:     rd_val = '0;
      endcase
   end

   // Shifter state survives soft reset so the CTRL write itself completes cleanly.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_q     <= '0;
         sdi_q     <= '0;
         sen_q     <= 2'b11;
         cnt       <= '0;
         sh        <= '0;
         rd_sh     <= '0;
         is_rd     <= 1'b0;
         spi_sdo   <= 1'b0;
         status_rd <= 1'b0;
      end else begin
         sck_q     <= {sck_q[1:0], spi_sck};
         sdi_q     <= {sdi_q[0], spi_sdi};
         sen_q     <= {sen_q[0], spi_sen_n};
         status_rd <= 1'b0;
         if (sen_s) begin
            cnt     <= '0;
            is_rd   <= 1'b0;
            spi_sdo <= 1'b0;
         end else begin
            if (rise && cnt != 5'd24) begin
               sh  <= {sh[21:0], sdi_s};
               cnt <= cnt + 5'd1;
               if (cnt == 5'd7) begin
                  is_rd     <= sh[6];
                  rd_sh     <= rd_val;
                  status_rd <= sh[6] && (rd_addr == ADDR_STATUS);
               end
            end
            if (fall) begin
               if (is_rd && cnt >= 5'd8 && cnt < 5'd24) begin
                  spi_sdo <= rd_sh[15];
                  rd_sh   <= {rd_sh[14:0], 1'b0};
               end else begin
                  spi_sdo <= 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || soft_rst) begin
         mode     <= MODE_NORMAL;
         fixed    <= 16'h1555;
         lines    <= 16'd1;
         soft_rst <= 1'b0;
`ifdef ROIC_ERR_INJECT_EN
         inj      <= '0;
`endif
      end else begin
`ifdef ROIC_ERR_INJECT_EN
         if (inj_clr) inj[15] <= 1'b0;
`endif
         if (wr_en) begin
            case (wr_addr)
               ADDR_CTRL:  soft_rst <= wr_data[0];
               ADDR_MODE:  mode     <= mode_e'(wr_data[1:0]);
               ADDR_FIXED: fixed    <= wr_data;
               ADDR_LINES: lines    <= wr_data;
`ifdef ROIC_ERR_INJECT_EN
               ADDR_INJ:   inj      <= wr_data;
`endif
               default:    ;
            endcase
         end
      end
   end

endmodule

// File: rtl/afe_roic_stream_model.sv
// rtl/afe_roic_stream_model.sv - ROIC LVDS readout model: frame FSM and serialiser; ROIC_ERR_INJECT_EN enables bit injection
module afe_roic_stream_model
   import afe_roic_pkg::*;
#(
   parameter int          NUM_CH       = 14,
   parameter int          PIXEL_W      = 14,
   parameter int          PIX_PER_LINE = 256,
   parameter int          LINE_GAP     = 8,
   parameter int          TRAIN_WORDS  = 4,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     avdd_ok,
   input  logic                     roic_sync,
   input  logic                     roic_tp_sel,
   afe_roic_stream_model_if.slave   bus,
   output logic                     frame_active,
   output logic [15:0]              line_idx
);
   state_e              state, state_nx;
   mode_e               mode, frame_mode;
   logic [15:0]         fixed, lines, lines_eff, word_cnt, lfsr;
   logic [13:0]         frame_cnt;
   logic [3:0]          bit_cnt;
   logic                ph, sync_d, sync_rise, overrun, soft_rst, status_rd, rst_i;
   logic                word_end, more_lines, streaming, framing, frame_start;
   logic [PIXEL_W-1:0]  word [NUM_CH];
   logic [NUM_CH-1:0]   dout;
`ifdef ROIC_ERR_INJECT_EN
   logic [15:0]         inj;
   logic                inj_clr, inj_pend;
   logic [4:0]          inj_ch;
   logic [3:0]          inj_bit;
`endif

   afe_roic_spi_slave u_spi (
      .clk       (clk),
      .rst       (rst),
      .spi_sck   (bus.spi_sck),
      .spi_sdi   (bus.spi_sdi),
      .spi_sen_n (bus.spi_sen_n),
      .spi_sdo   (bus.spi_sdo),
      .status    ({frame_cnt, overrun, frame_active}),
`ifdef ROIC_ERR_INJECT_EN
      .inj_clr   (inj_clr),
      .inj       (inj),
`endif
      .mode      (mode),
      .fixed     (fixed),
      .lines     (lines),
      .soft_rst  (soft_rst),
      .status_rd (status_rd)
   );

   assign rst_i       = rst | soft_rst;
   assign sync_rise   = roic_sync & ~sync_d;
   assign lines_eff   = (lines == 16'd0) ? 16'd1 : lines;
   assign word_end    = ph && (bit_cnt == 4'(PIXEL_W - 1));
   assign more_lines  = (17'(line_idx) + 17'd1) < 17'(lines_eff);
   assign streaming   = (state == ST_PREAMBLE) || (state == ST_LINE) || (state == ST_GAP);
   assign framing     = (state == ST_PREAMBLE) || (state == ST_LINE);
   assign frame_start = (state == ST_IDLE) && (state_nx == ST_PREAMBLE);
   assign frame_active = (state != ST_IDLE);

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:     if (sync_rise && mode != MODE_SLEEP) state_nx = ST_PREAMBLE;
         ST_PREAMBLE: if (word_end && word_cnt == 16'(TRAIN_WORDS - 1)) state_nx = ST_LINE;
         ST_LINE:     if (word_end && word_cnt == 16'(PIX_PER_LINE - 1)) state_nx = ST_GAP;
         ST_GAP:      if (ph && word_cnt == 16'(LINE_GAP - 1)) state_nx = more_lines ? ST_LINE : ST_DONE;
         ST_DONE:     state_nx = ST_IDLE;
         default:     state_nx = ST_IDLE;
      endcase
      if (!avdd_ok) state_nx = ST_IDLE;
   end

   // word_cnt counts words in PREAMBLE/LINE and idle bit periods in GAP.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         ph         <= 1'b0;
         bit_cnt    <= '0;
         word_cnt   <= '0;
         line_idx   <= '0;
         frame_cnt  <= '0;
         overrun    <= 1'b0;
         frame_mode <= MODE_NORMAL;
         lfsr       <= LFSR_SEED;
         sync_d     <= 1'b0;
      end else begin
         state  <= state_nx;
         sync_d <= roic_sync;
         if (status_rd) overrun <= 1'b0;
         if (sync_rise && state != ST_IDLE) overrun <= 1'b1;
         if (state_nx != state) begin
            ph       <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= '0;
         end else if (streaming) begin
            ph <= ~ph;
            if (ph) begin
               if (state == ST_GAP || bit_cnt == 4'(PIXEL_W - 1)) begin
                  bit_cnt  <= '0;
                  word_cnt <= word_cnt + 16'd1;
               end else begin
                  bit_cnt  <= bit_cnt + 4'd1;
               end
            end
         end
         if (frame_start) begin
            line_idx   <= '0;
            frame_mode <= (mode == MODE_NORMAL && roic_tp_sel) ? MODE_RAMP : mode;
         end
         if (state == ST_GAP && state_nx == ST_LINE) line_idx <= line_idx + 16'd1;
         if (state == ST_LINE && word_end && frame_mode == MODE_NORMAL) lfsr <= lfsr_step(lfsr);
         if (state == ST_DONE && avdd_ok) frame_cnt <= frame_cnt + 14'd1;
      end
   end

`ifdef ROIC_ERR_INJECT_EN
   assign inj_clr = inj_pend && state == ST_LINE && line_idx == 16'd0 && word_cnt == 16'd0 && word_end;

   always_ff @(posedge clk) begin
      if (rst_i) begin
         inj_pend <= 1'b0;
         inj_ch   <= '0;
         inj_bit  <= '0;
      end else if (frame_start) begin
         inj_pend <= inj[15];
         inj_ch   <= inj[4:0];
         inj_bit  <= inj[11:8];
      end else if (inj_clr) begin
         inj_pend <= 1'b0;
      end
   end
`endif

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         case (frame_mode)
            MODE_NORMAL: word[c] = PIXEL_W'(lfsr ^ 16'(c));
            MODE_RAMP:   word[c] = PIXEL_W'(word_cnt + line_idx + 16'(c));
            MODE_FIXED:  word[c] = PIXEL_W'(fixed);
            default:     word[c] = '0;
         endcase
         if (state == ST_PREAMBLE) word[c] = PIXEL_W'(train_word(PIXEL_W));
`ifdef ROIC_ERR_INJECT_EN
         if (inj_pend && state == ST_LINE && line_idx == 16'd0 && word_cnt == 16'd0 &&
             inj_ch == 5'(c) && 32'(inj_bit) < PIXEL_W)
            word[c][inj_bit] = ~word[c][inj_bit];
`endif
         dout[c] = framing & word[c][4'(PIXEL_W - 1) - bit_cnt];
      end
   end

   assign bus.dclk_p = {NUM_CH{streaming & ph}};
   assign bus.dclk_n = ~bus.dclk_p;
   assign bus.fclk_p = {NUM_CH{framing && bit_cnt < 4'(PIXEL_W / 2)}};
   assign bus.fclk_n = ~bus.fclk_p;
   assign bus.dout_p = dout;
   assign bus.dout_n = ~dout;

endmodule
